// File: rtl/led_scan_sequencer.sv
// Frame/scanline scheduler for the multiplexed LED driver (grayscale clock domain).
// Per row: LOAD slot (vsync low), optional dead-time BLANK, then PWM SCAN (vsync high).
// Owns the shared PWM counter and row driver enable, and swaps the double-buffered
// frame store banks only at frame boundaries.
// Optional build macro LEDSEQ_STATUS_EN adds frame_cnt and underrun status outputs.
module led_scan_sequencer #(
    parameter int ROWS     = 32,
    parameter int ROW_W    = 5,
    parameter int PWM_W    = 16,
    parameter int LOAD_CYC = 2,
    parameter int DEAD_CYC = 4
) (
    input  logic             gck,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic             frame_ready,
    output logic             vsync,
    output logic [ROW_W-1:0] row_sel,
    output logic             row_en,
    output logic [PWM_W-1:0] pwm_cnt,
    output logic             bank_sel,
    output logic             frame_ack,
    output logic             frame_done
`ifdef LEDSEQ_STATUS_EN
    ,
    output logic [15:0]      frame_cnt,
    output logic             underrun
`endif
);

    localparam int PH_MAX = (LOAD_CYC > DEAD_CYC) ? LOAD_CYC : DEAD_CYC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0]  LOAD_LAST = PH_W'(LOAD_CYC - 1);
    localparam logic [PH_W-1:0]  DEAD_LAST = PH_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
    localparam logic [PWM_W-1:0] TERM_FULL = '1;
    localparam logic [PWM_W-1:0] TERM_HALF = PWM_W'((1 << (PWM_W - 1)) - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BLANK,
        S_SCAN
    } state_t;

    state_t            state, state_d;
    logic [ROW_W-1:0]  row, row_d;
    logic [PWM_W-1:0]  cnt, cnt_d;
    logic [PH_W-1:0]   phase, phase_d;
    logic              half, half_d;
    logic              mode_q, mode_d;
    logic              ready_pend, pend_d;
    logic              bank_d, ack_d, done_d;
    logic              vsync_d, row_en_d;
    logic [PWM_W-1:0]  pwm_d;
    logic [PWM_W-1:0]  term, term_d;
    logic              start, swap;

    assign term = mode_q ? TERM_HALF : TERM_FULL;

    // Next-state, counters, bank arbitration and next registered output values.
    // Outputs are registered, so frame_done is predicted from the next-cycle state.
    always_comb begin
        state_d = state;
        row_d   = row;
        cnt_d   = cnt;
        phase_d = phase;
        half_d  = half;
        mode_d  = mode_q;
        pend_d  = ready_pend;
        bank_d  = bank_sel;
        ack_d   = 1'b0;
        start   = 1'b0;
        swap    = 1'b0;

        case (state)
            S_IDLE: begin
                if (enable) begin
                    start   = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (phase == LOAD_LAST) begin
                    phase_d = '0;
                    cnt_d   = '0;
                    state_d = (DEAD_CYC == 0) ? S_SCAN : S_BLANK;
                end else begin
                    phase_d = phase + PH_W'(1);
                end
            end
            S_BLANK: begin
                if (phase == DEAD_LAST) begin
                    phase_d = '0;
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end else begin
                    phase_d = phase + PH_W'(1);
                end
            end
            S_SCAN: begin
                if (cnt == term) begin
                    cnt_d = '0;
                    if (row != ROW_LAST) begin
                        row_d   = row + ROW_W'(1);
                        state_d = S_LOAD;
                    end else if (mode_q && !half) begin
                        half_d  = 1'b1;
                        row_d   = '0;
                        state_d = S_LOAD;
                    end else if (enable) begin
                        start   = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        row_d   = '0;
                        half_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt + PWM_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pulse coinciding with the frame-start cycle is taken directly;
        // any other pulse is parked in ready_pend, so repeats collapse.
        if (start) begin
            mode_d  = mode;
            row_d   = '0;
            half_d  = 1'b0;
            cnt_d   = '0;
            phase_d = '0;
            if (ready_pend || frame_ready) begin
                swap   = 1'b1;
                bank_d = ~bank_sel;
                ack_d  = 1'b1;
                pend_d = 1'b0;
            end
        end else if (frame_ready) begin
            pend_d = 1'b1;
        end

        term_d   = mode_d ? TERM_HALF : TERM_FULL;
        vsync_d  = (state_d == S_SCAN);
        row_en_d = (state_d == S_SCAN);
        pwm_d    = '0;
        if (state_d == S_SCAN) begin
            pwm_d = mode_d ? {half_d, cnt_d[PWM_W-2:0]} : cnt_d;
        end
        done_d = (state_d == S_SCAN) && (cnt_d == term_d) && (row_d == ROW_LAST)
                 && (!mode_d || half_d);
    end

    // State register, counters and registered outputs; async reset drops a pending swap.
    always_ff @(posedge gck or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            row        <= '0;
            cnt        <= '0;
            phase      <= '0;
            half       <= 1'b0;
            mode_q     <= 1'b0;
            ready_pend <= 1'b0;
            bank_sel   <= 1'b0;
            frame_ack  <= 1'b0;
            frame_done <= 1'b0;
            vsync      <= 1'b0;
            row_en     <= 1'b0;
            row_sel    <= '0;
            pwm_cnt    <= '0;
        end else begin
            state      <= state_d;
            row        <= row_d;
            cnt        <= cnt_d;
            phase      <= phase_d;
            half       <= half_d;
            mode_q     <= mode_d;
            ready_pend <= pend_d;
            bank_sel   <= bank_d;
            frame_ack  <= ack_d;
            frame_done <= done_d;
            vsync      <= vsync_d;
            row_en     <= row_en_d;
            row_sel    <= row_d;
            pwm_cnt    <= pwm_d;
        end
    end

`ifdef LEDSEQ_STATUS_EN
    // Frame counter follows frame_done; underrun flags a frame start that repeats a bank.
    always_ff @(posedge gck or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            underrun  <= 1'b0;
        end else begin
            if (done_d) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (start) begin
                underrun <= ~swap;
            end
        end
    end
`endif

endmodule
